// File: rtl/ps2_key_decoder_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
package ps2_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int KEY_TOGGLE  = 10;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_EXT     = 8;

  // Odd parity over data+parity, and the stop bit must be high.
  function automatic logic frame_ok(input logic [7:0] b, input logic p, input logic stop);
    return (^{b, p}) & stop;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// PS/2 line inputs and decoded event outputs of the keyboard front end.
interface ps2_key_decoder_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic        busy;

  modport master (output ps2_clk, ps2_data, input ps2_key, frame_err, busy);
  modport slave  (input ps2_clk, ps2_data, output ps2_key, frame_err, busy);
endinterface

// File: rtl/ps2_key_decoder_input_filter.sv
// 2-FF synchroniser followed by a stability filter; output changes only
// after FILTER_LEN consecutive samples of the new level.
module ps2_input_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_i,
  output logic line_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  always_comb begin
    sync_d = {sync_q[0], line_i};
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = sync_q[1];
      else                              cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign line_o = filt_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 deserialiser: frames bytes off the filtered lines, folds E0/F0
// prefixes into flags and emits one toggle-signalled event per key code.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic             clk,
  input  logic             reset_n,
  ps2_key_decoder_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic kclk_f, kdat_f;

  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_flt (
    .clk(clk), .reset_n(reset_n), .line_i(bus.ps2_clk), .line_o(kclk_f)
  );
  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_flt (
    .clk(clk), .reset_n(reset_n), .line_i(bus.ps2_data), .line_o(kdat_f)
  );

  ps2_state_e    state_q, state_d;
  logic          kclk_q;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    bit_q, bit_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [10:0]   key_q, key_d;
  logic          err_q, err_d;

  logic fall, tout, edge_ok;

  assign fall    = kclk_q & ~kclk_f;
  assign tout    = (state_q != IDLE) && (to_q == TW'(TIMEOUT_CYC));
  // Timeout has priority over a coincident falling edge.
  assign edge_ok = fall & ~tout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      kclk_q  <= 1'b1;
      sh_q    <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      to_q    <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      key_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kclk_q  <= kclk_f;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      to_q    <= to_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      key_q   <= key_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tout) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (edge_ok && !kdat_f) state_d = START;
        START:   state_d = DATA;
        DATA:    if (edge_ok && bit_q == 3'd7) state_d = PARITY;
        PARITY:  if (edge_ok) state_d = STOP;
        STOP:    if (edge_ok) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sh_d  = sh_q;
    bit_d = bit_q;
    par_d = par_q;
    ext_d = ext_q;
    brk_d = brk_q;
    key_d = key_q;
    err_d = 1'b0;
    to_d  = (state_q == IDLE || fall || tout) ? '0 : to_q + TW'(1);
    if (state_q == IDLE) bit_d = '0;
    if (tout) begin
      err_d = 1'b1;
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (edge_ok) begin
      case (state_q)
        DATA: begin
          sh_d  = {kdat_f, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
        end
        PARITY: par_d = kdat_f;
        STOP: begin
          if (!frame_ok(sh_q, par_q, kdat_f)) begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end else if (sh_q == PS2_EXT) begin
            ext_d = 1'b1;
          end else if (sh_q == PS2_BRK) begin
            brk_d = 1'b1;
          end else begin
            key_d[7:0]         = sh_q;
            key_d[KEY_EXT]     = ext_q;
            key_d[KEY_PRESSED] = ~brk_q;
            key_d[KEY_TOGGLE]  = ~key_q[KEY_TOGGLE];
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ps2_key   = key_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomised frame stimulus checked against a byte-level model of the
// prefix/event rules, plus directed glitch, timeout and reset cases.
module tb_ps2_key_decoder;

  localparam int FL = 8;
  localparam int TO = 1000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  ps2_key_decoder_if bus();

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // monitor, sampled on the falling clock edge
  int          cyc = 0, tog_cnt = 0, err_cnt = 0, wide_cnt = 0;
  int          key_chg_cyc = 0, busy_fall_cyc = 0, err_cyc = 0;
  logic [10:0] prev_key = '0;
  logic        prev_err = 1'b0, prev_busy = 1'b0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (bus.ps2_key[10] !== prev_key[10]) tog_cnt++;
    if (bus.ps2_key !== prev_key) key_chg_cyc = cyc;
    if (bus.frame_err) begin
      err_cnt++;
      err_cyc = cyc;
      if (prev_err) wide_cnt++;
    end
    if (prev_busy && !bus.busy) busy_fall_cyc = cyc;
    prev_key  = bus.ps2_key;
    prev_err  = bus.frame_err;
    prev_busy = bus.busy;
  end

  // reference model state
  logic [10:0] m_key = '0;
  bit          m_ext = 0, m_brk = 0;
  int          stop_cyc = 0;

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  // nfalls clock pulses of a frame; optional FL-2 wide clock glitch before fall glitch_at
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nfalls, input int glitch_at, input int half);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nfalls; i++) begin
      bus.ps2_data = bits[i];
      if (glitch_at == i) begin
        tick(half / 2);
        bus.ps2_clk = 1'b0;
        tick(FL - 2);
        bus.ps2_clk = 1'b1;
        tick(half - half / 2);
      end else tick(half);
      bus.ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      tick(half);
      if (i == 0) chk("busy_in_frame", 32'(bus.busy), 32'd1);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
  endtask

  // model: returns 1 when the byte is expected to produce an event, 2 on error
  function automatic int model_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_par || bad_stop) begin
      m_ext = 0; m_brk = 0;
      return 2;
    end
    if (b == 8'hE0) begin m_ext = 1; return 0; end
    if (b == 8'hF0) begin m_brk = 1; return 0; end
    m_key = {~m_key[10], ~m_brk, m_ext, b};
    m_ext = 0; m_brk = 0;
    return 1;
  endfunction

  task automatic do_frame(input logic [7:0] b, input bit bp, input bit bs,
                          input int glitch_at, input int half);
    int t0, e0, r;
    t0 = tog_cnt;
    e0 = err_cnt;
    send_frame(b, bp, bs, 11, glitch_at, half);
    tick(3 * FL + 10);
    r = model_byte(b, bp, bs);
    chk("key", 32'(bus.ps2_key), 32'(m_key));
    chk("toggles", tog_cnt - t0, (r == 1) ? 1 : 0);
    chk("errs", err_cnt - e0, (r == 2) ? 1 : 0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("busy_fall_lat", busy_fall_cyc - stop_cyc, FL + 3);
    if (r == 1) chk("key_vs_busy", key_chg_cyc, busy_fall_cyc);
    if (r == 2) chk("err_vs_busy", err_cyc, busy_fall_cyc);
  endtask

  initial begin
    int t0, e0, half, k;
    logic [7:0] b;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    tick(5);
    chk("rst_key", 32'(bus.ps2_key), 32'h0);
    chk("rst_err", 32'(bus.frame_err), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    reset_n = 1'b1;
    tick(20);

    do_frame(8'h1C, 0, 0, -1, 20);
    chk("make_1c", 32'(bus.ps2_key), 32'h61C);
    do_frame(8'hF0, 0, 0, -1, 20);
    do_frame(8'h1C, 0, 0, -1, 20);
    chk("break_1c", 32'(bus.ps2_key), 32'h01C);
    do_frame(8'hE0, 0, 0, -1, 20);
    do_frame(8'hF0, 0, 0, -1, 20);
    do_frame(8'h75, 0, 0, -1, 20);
    chk("ext_break_75", 32'(bus.ps2_key), 32'h575);
    do_frame(8'h1C, 1, 0, -1, 20);
    do_frame(8'h32, 0, 0, -1, 20);
    chk("after_perr", 32'(bus.ps2_key[7:0]), 32'h32);

    // glitch on clock while idle with data low: must not start a frame
    bus.ps2_data = 1'b0;
    tick(20);
    bus.ps2_clk = 1'b0;
    tick(FL - 2);
    bus.ps2_clk = 1'b1;
    tick(30);
    chk("glitch_idle_busy", 32'(bus.busy), 32'd0);
    bus.ps2_data = 1'b1;
    tick(30);
    do_frame(8'h5A, 0, 0, 0, 24);
    do_frame(8'h2B, 0, 0, 4, 24);

    // timeout after 5 data bits, with a pending E0 that must be dropped
    do_frame(8'hE0, 0, 0, -1, 20);
    t0 = tog_cnt;
    e0 = err_cnt;
    send_frame(8'h33, 0, 0, 6, -1, 20);
    tick(TO + 50);
    m_ext = 0; m_brk = 0;
    chk("tout_err", err_cnt - e0, 1);
    chk("tout_busy", 32'(bus.busy), 32'd0);
    chk("tout_key", 32'(bus.ps2_key), 32'(m_key));
    chk("tout_tog", tog_cnt - t0, 0);
    do_frame(8'h1C, 0, 0, -1, 20);

    // randomised traffic
    for (int n = 0; n < 30; n++) begin
      half = $urandom_range(15, 30);
      k = $urandom_range(0, 3);
      b = (k == 0) ? 8'hE0 : (k == 1) ? 8'hF0 : 8'($urandom);
      do_frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0), -1, half);
    end

    // reset mid-frame
    send_frame(8'h44, 0, 0, 4, -1, 20);
    reset_n = 1'b0;
    #1;
    chk("midrst_key", 32'(bus.ps2_key), 32'h0);
    chk("midrst_err", 32'(bus.frame_err), 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    m_key = '0; m_ext = 0; m_brk = 0;
    tick(5);
    reset_n = 1'b1;
    tick(20);
    do_frame(8'h16, 0, 0, -1, 20);
    chk("post_rst_key", 32'(bus.ps2_key), 32'h616);

    chk("err_pulse_width", wide_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
